// File: rtl/dma_rd_req_gen.sv
// -----------------------------------------------------------------------------
// dma_rd_req_gen
//
// Purpose:
//   Turns host-memory read commands (byte address + byte length) into a stream
//   of PCIe Memory Read requests for the DMA TX arbiter. Each command is split
//   into requests of at most MAX_RD_REQ bytes that never cross a
//   MAX_RD_REQ-aligned boundary. Each request is one 128-bit RQ descriptor beat.
//   Tags are handed out round-robin and tracked in a busy bitmap. The
//   completion path clears bits in that bitmap.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_req_id[15:0]    requester ID stamped into every descriptor
//   cmd_addr[63:0]      command start byte address
//   cmd_len[31:0]       command length in bytes (0 = no request, just done)
//   cmd_valid/ready     command handshake
//   cmd_done            one-cycle pulse after the command's last descriptor
//   tag_rel_valid/id    completion path releases a tag
//   dma_rd_data[127:0]  RQ descriptor
//   dma_rd_user[59:0]   [3:0] first_be, [7:4] last_be, remaining bits 0
//   dma_rd_keep[3:0]    4'hF while valid
//   dma_rd_last         1 while valid (single-beat descriptors)
//   dma_rd_valid/ready  descriptor handshake
// -----------------------------------------------------------------------------
module dma_rd_req_gen #(
    parameter int MAX_RD_REQ = 512,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          cfg_req_id,
    input  logic [63:0]          cmd_addr,
    input  logic [31:0]          cmd_len,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    output logic                 cmd_done,
    input  logic                 tag_rel_valid,
    input  logic [TAG_WIDTH-1:0] tag_rel_id,
    output logic [127:0]         dma_rd_data,
    output logic [59:0]          dma_rd_user,
    output logic [3:0]           dma_rd_keep,
    output logic                 dma_rd_last,
    output logic                 dma_rd_valid,
    input  logic                 dma_rd_ready
);

    // Offset bits inside one MAX_RD_REQ window.
    localparam int OFF_W    = $clog2(MAX_RD_REQ);
    localparam int NUM_TAGS = 1 << TAG_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [63:0]            r_cur_addr;
    logic [31:0]            r_rem;
    logic [12:0]            r_chunk;
    logic [127:0]           r_desc;
    logic [7:0]             r_be;          // {last_be, first_be}
    logic [TAG_WIDTH-1:0]   r_tag_ptr;
    logic [NUM_TAGS-1:0]    r_busy;
    logic [NUM_TAGS-1:0]    w_busy_next;

    logic                   w_cmd_hs;
    logic                   w_send_hs;
    logic                   w_tag_free;
    logic                   w_rem_is_last;

    // Chunk / descriptor computation (used in CALC).
    logic [12:0]            w_room;
    logic [12:0]            w_chunk;
    logic [10:0]            w_dw;
    logic [1:0]             w_end_lo;
    logic [1:0]             w_last_shift;
    logic [3:0]             w_first_be_raw;
    logic [3:0]             w_last_be_raw;
    logic [3:0]             w_first_be;
    logic [3:0]             w_last_be;
    logic [127:0]           w_desc;

    // -------------------------------------------------------------------------
    // Chunk sizing: bytes left until the next MAX_RD_REQ boundary, capped by
    // the remaining length. MAX_RD_REQ itself (up to 4096) fits in 13 bits.
    // -------------------------------------------------------------------------
    assign w_room  = 13'(MAX_RD_REQ) - 13'(r_cur_addr[OFF_W-1:0]);
    assign w_chunk = (r_rem < 32'(w_room)) ? r_rem[12:0] : w_room;

    // DW count covers the partial leading DW introduced by the byte offset.
    assign w_dw = 11'((14'(r_cur_addr[1:0]) + 14'(w_chunk) + 14'd3) >> 2);

    // Byte enables. The last-BE shift is (4 - end_offset) mod 4, which in
    // 2-bit arithmetic is simply the negated end offset.
    assign w_end_lo       = r_cur_addr[1:0] + w_chunk[1:0];
    assign w_last_shift   = 2'd0 - w_end_lo;
    assign w_first_be_raw = 4'hF << r_cur_addr[1:0];
    assign w_last_be_raw  = 4'hF >> w_last_shift;

    // A request that fits in one DW carries all its enables in first_be.
    always_comb begin
        w_first_be = w_first_be_raw;
        w_last_be  = w_last_be_raw;
        if (w_dw == 11'd1) begin
            w_first_be = w_first_be_raw & w_last_be_raw;
            w_last_be  = 4'h0;
        end
    end

    // RQ descriptor: memory read, no attributes, tag zero-extended to 8 bits.
    assign w_desc = {
        7'd0,                   // [127:121]
        1'b0,                   // [120]
        16'd0,                  // [119:104]
        8'(r_tag_ptr),          // [103:96]
        cfg_req_id,             // [95:80]
        1'b0,                   // [79]
        4'b0000,                // [78:75] memory read
        w_dw,                   // [74:64]
        r_cur_addr[63:2],       // [63:2]
        2'b00                   // [1:0]
    };

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Round-robin only: a busy tag at the pointer stalls the stream even if
    // other tags are free.
    assign w_tag_free    = ~r_busy[r_tag_ptr];
    assign w_rem_is_last = (r_rem == 32'(r_chunk));

    // -------------------------------------------------------------------------
    // FSM: next state and outputs. Outputs are masked while rst is high so a
    // command or descriptor cannot appear to complete in a cycle being reset.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cmd_hs     = 1'b0;
        w_send_hs    = 1'b0;
        cmd_ready    = 1'b0;
        cmd_done     = 1'b0;
        dma_rd_valid = 1'b0;

        case (r_state)
            ST_IDLE: begin
                cmd_ready = ~rst;
                if (cmd_valid) begin
                    w_cmd_hs     = 1'b1;
                    w_state_next = (cmd_len == 32'd0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                dma_rd_valid = w_tag_free & ~rst;
                if (w_tag_free && dma_rd_ready) begin
                    w_send_hs    = 1'b1;
                    w_state_next = w_rem_is_last ? ST_DONE : ST_CALC;
                end
            end
            ST_DONE: begin
                cmd_done     = ~rst;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Tag busy bitmap. A release is applied before an allocation of the same
    // tag in the same cycle, so the allocation wins and the tag ends up busy.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TAGS; gi++) begin : g_busy
            assign w_busy_next[gi] =
                (w_send_hs && (r_tag_ptr == TAG_WIDTH'(gi)))         ? 1'b1 :
                (tag_rel_valid && (tag_rel_id == TAG_WIDTH'(gi)))    ? 1'b0 :
                                                                      r_busy[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_addr <= 64'd0;
            r_rem      <= 32'd0;
            r_chunk    <= 13'd0;
            r_desc     <= 128'd0;
            r_be       <= 8'd0;
            r_tag_ptr  <= '0;
            r_busy     <= '0;
        end else begin
            r_busy <= w_busy_next;

            if (w_cmd_hs) begin
                r_cur_addr <= cmd_addr;
                r_rem      <= cmd_len;
            end

            // Descriptor is frozen from CALC through SEND, so it stays stable
            // under backpressure and tag stalls.
            if (r_state == ST_CALC) begin
                r_chunk <= w_chunk;
                r_desc  <= w_desc;
                r_be    <= {w_last_be, w_first_be};
            end

            if (w_send_hs) begin
                r_cur_addr <= r_cur_addr + 64'(r_chunk);   // wraps at 2^64
                r_rem      <= r_rem - 32'(r_chunk);
                r_tag_ptr  <= r_tag_ptr + TAG_WIDTH'(1);
            end
        end
    end

    assign dma_rd_data = r_desc;
    assign dma_rd_user = {52'd0, r_be};
    assign dma_rd_keep = dma_rd_valid ? 4'hF : 4'h0;
    assign dma_rd_last = dma_rd_valid;

endmodule

// File: tb/tb_dma_rd_req_gen.sv
// -----------------------------------------------------------------------------
// tb_dma_rd_req_gen
//
// Commands are split by a reference model into expected descriptors that are
// queued when the command is issued. An independent monitor pops and compares
// on every descriptor handshake, tracks the tag busy state, checks cmd_done
// timing and output stability under backpressure. Directed scenarios are
// followed by a randomized phase with random ready and random tag releases.
// -----------------------------------------------------------------------------
module tb_dma_rd_req_gen;

    localparam int MAX = 512;
    localparam int TW  = 2;
    localparam int NT  = 1 << TW;

    typedef struct {
        logic [127:0] data;
        logic [59:0]  user;
        bit           is_last;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [15:0]    cfg_req_id = 16'h0;
    logic [63:0]    cmd_addr = 64'd0;
    logic [31:0]    cmd_len = 32'd0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cmd_done;
    logic           tag_rel_valid = 1'b0;
    logic [TW-1:0]  tag_rel_id = '0;
    logic [127:0]   dma_rd_data;
    logic [59:0]    dma_rd_user;
    logic [3:0]     dma_rd_keep;
    logic           dma_rd_last;
    logic           dma_rd_valid;
    logic           dma_rd_ready = 1'b0;

    always #5 clk = ~clk;

    dma_rd_req_gen #(
        .MAX_RD_REQ (MAX),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_req_id    (cfg_req_id),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_done      (cmd_done),
        .tag_rel_valid (tag_rel_valid),
        .tag_rel_id    (tag_rel_id),
        .dma_rd_data   (dma_rd_data),
        .dma_rd_user   (dma_rd_user),
        .dma_rd_keep   (dma_rd_keep),
        .dma_rd_last   (dma_rd_last),
        .dma_rd_valid  (dma_rd_valid),
        .dma_rd_ready  (dma_rd_ready)
    );

    int     tests = 0;
    int     fails = 0;

    exp_t   exp_q[$];          // expected descriptors (driver pushes)
    int     push_tag = 0;      // tags assigned by the model, round-robin
    int     len0_issued = 0;   // zero-length commands issued (driver)
    int     len0_used = 0;     // zero-length cmd_done pulses seen (monitor)

    // Monitor-owned model state
    int     hs_count = 0;
    bit     model_busy[NT];
    int     outstanding[$];
    bit     done_due = 1'b0;
    int     done_seen = 0;

    // Stimulus controls
    bit     ready_random = 1'b0;
    logic   ready_force = 1'b1;
    bit     auto_rel = 1'b0;
    int     man_rel_seq = 0;
    int     man_rel_id = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: one read request covering [addr, addr+chunk).
    function automatic exp_t make_desc(input logic [63:0] addr, input int unsigned chunk,
                                       input int tag, input bit is_last);
        exp_t        e;
        int unsigned off;
        int unsigned dw;
        int unsigned fin;
        logic [3:0]  fbe;
        logic [3:0]  lbe;
        off = 32'(addr[1:0]);
        dw  = (off + chunk + 3) / 4;
        fbe = 4'hF << off;
        fin = (off + chunk) % 4;
        lbe = 4'hF >> ((4 - fin) % 4);
        if (dw == 1) begin
            fbe = fbe & lbe;
            lbe = 4'h0;
        end
        e.data          = '0;
        e.data[63:2]    = addr[63:2];
        e.data[74:64]   = 11'(dw);
        e.data[95:80]   = cfg_req_id;
        e.data[103:96]  = 8'(tag);
        e.user          = {52'd0, lbe, fbe};
        e.is_last       = is_last;
        return e;
    endfunction

    // Split the command with the model, then drive it. Caller is at posedge+1.
    task automatic issue_cmd(input logic [63:0] addr, input logic [31:0] len);
        logic [63:0]     a;
        longint unsigned r;
        int unsigned     room;
        int unsigned     c;
        int              b;
        b = 0;
        while (!cmd_ready && b < 5000) begin
            @(posedge clk); #1;
            b++;
        end
        chk("cmd_ready_wait", 128'(cmd_ready), 128'(1));
        a = addr;
        r = 64'(len);
        if (len == 32'd0) len0_issued++;
        while (r > 0) begin
            room = MAX - 32'(a % 64'(MAX));
            c    = (r < 64'(room)) ? 32'(r) : room;
            exp_q.push_back(make_desc(a, c, push_tag % NT, r == 64'(c)));
            push_tag++;
            a = a + 64'(c);
            r = r - 64'(c);
        end
        $display("[TB] cmd addr=%h len=%0d", addr, len);
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || !cmd_ready || done_due) && b < 5000) begin
            @(posedge clk); #1;
            b++;
        end
        chk("idle_pending", 128'(exp_q.size()), 128'(0));
        chk("idle_cmd_ready", 128'(cmd_ready), 128'(1));
    endtask

    // Reset for one cycle; outputs are checked while rst is still high.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_valid", 128'(dma_rd_valid), 128'(0));
        chk("rst_cmd_ready", 128'(cmd_ready), 128'(0));
        chk("rst_cmd_done", 128'(cmd_done), 128'(0));
        chk("rst_data", dma_rd_data, 128'(0));
        chk("rst_user", 128'(dma_rd_user), 128'(0));
        chk("rst_keep_last", 128'({dma_rd_keep, dma_rd_last}), 128'(0));
        exp_q.delete();
        push_tag = 0;
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 128'(cmd_ready), 128'(1));
    endtask

    // Downstream ready driver
    initial begin
        forever begin
            @(posedge clk); #1;
            dma_rd_ready = ready_random ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Tag release driver (completion path stand-in)
    initial begin
        int last_seq;
        last_seq = 0;
        forever begin
            @(posedge clk); #1;
            tag_rel_valid = 1'b0;
            if (man_rel_seq != last_seq) begin
                last_seq      = man_rel_seq;
                tag_rel_valid = 1'b1;
                tag_rel_id    = TW'(man_rel_id);
            end else if (auto_rel && $urandom_range(0, 2) == 0) begin
                tag_rel_valid = 1'b1;
                if (outstanding.size() > 0 && $urandom_range(0, 3) != 0)
                    tag_rel_id = TW'(outstanding.pop_front());
                else
                    tag_rel_id = TW'($urandom_range(0, NT - 1));
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit           hs;
        bit           prev_stall;
        logic [127:0] prev_data;
        logic [59:0]  prev_user;
        exp_t         e;
        int           t;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_user  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                done_due   = 1'b0;
                hs_count   = 0;
                outstanding.delete();
                for (int i = 0; i < NT; i++) model_busy[i] = 1'b0;
            end else begin
                hs = dma_rd_valid && dma_rd_ready;
                if (dma_rd_valid) begin
                    chk("keep", 128'(dma_rd_keep), 128'(4'hF));
                    chk("last", 128'(dma_rd_last), 128'(1));
                    chk("valid_while_tag_busy", 128'(model_busy[hs_count % NT]), 128'(0));
                end
                if (prev_stall) begin
                    chk("hold_valid", 128'(dma_rd_valid), 128'(1));
                    chk("hold_data", dma_rd_data, prev_data);
                    chk("hold_user", 128'(dma_rd_user), 128'(prev_user));
                end
                if (done_due) begin
                    chk("cmd_done_after_last", 128'(cmd_done), 128'(1));
                end else if (cmd_done) begin
                    if (len0_used < len0_issued) len0_used++;
                    else chk("cmd_done_unexpected", 128'(cmd_done), 128'(0));
                end
                if (cmd_done) done_seen++;
                done_due = 1'b0;
                // Release lands before a same-cycle allocation.
                if (tag_rel_valid) model_busy[tag_rel_id] = 1'b0;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        chk("desc_unexpected", 128'(exp_q.size()), 128'(1));
                    end else begin
                        e = exp_q.pop_front();
                        chk("desc_data", dma_rd_data, e.data);
                        chk("desc_user", 128'(dma_rd_user), 128'(e.user));
                        if (e.is_last) done_due = 1'b1;
                    end
                    t = hs_count % NT;
                    $display("[TB] desc #%0d tag=%0d addr=%h dw=%0d be=%h", hs_count,
                             dma_rd_data[103:96], {dma_rd_data[63:2], 2'b00},
                             dma_rd_data[74:64], dma_rd_user[7:0]);
                    model_busy[t] = 1'b1;
                    outstanding.push_back(t);
                    hs_count++;
                end
                prev_stall = dma_rd_valid && !dma_rd_ready;
                prev_data  = dma_rd_data;
                prev_user  = dma_rd_user;
            end
        end
    end

    // Safety net
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        int b;
        int hs0;
        int done0;
        logic [63:0] addr;
        logic [31:0] len;

        cfg_req_id = 16'($urandom);
        ready_random = 1'b0;
        ready_force  = 1'b1;
        auto_rel     = 1'b1;

        // Reset state
        do_reset();

        // Aligned single request
        issue_cmd(64'h1000, 32'd256);
        wait_idle();

        // Boundary split, tags 0 and 1 from a fresh reset
        do_reset();
        issue_cmd(64'h1F0, 32'h40);
        wait_idle();

        // Byte-unaligned
        do_reset();
        issue_cmd(64'h1003, 32'd2);
        issue_cmd(64'h1001, 32'd2);
        wait_idle();

        // Zero length: single cmd_done, no descriptor
        hs0   = hs_count;
        done0 = done_seen;
        issue_cmd(64'h7000, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("len0_done_once", 128'(done_seen - done0), 128'(1));
        chk("len0_no_desc", 128'(hs_count - hs0), 128'(0));

        // Backpressure: ready low for 10 cycles while valid
        do_reset();
        ready_force = 1'b0;
        issue_cmd(64'h3000, 32'd64);
        b = 0;
        while (!dma_rd_valid && b < 20) begin @(negedge clk); b++; end
        chk("bp_valid_up", 128'(dma_rd_valid), 128'(1));
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid_held", 128'(dma_rd_valid), 128'(1));
        end
        hs0 = hs_count;
        ready_force = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        chk("bp_handshake", 128'(hs_count - hs0), 128'(1));
        chk("bp_valid_after", 128'(dma_rd_valid), 128'(0));
        wait_idle();

        // Tag exhaustion
        do_reset();
        auto_rel    = 1'b0;
        ready_force = 1'b1;
        issue_cmd(64'h0, 32'd2560);
        repeat (30) @(posedge clk);
        #1;
        chk("exh_four_issued", 128'(hs_count), 128'(4));
        chk("exh_one_pending", 128'(exp_q.size()), 128'(1));
        chk("exh_stalled", 128'(dma_rd_valid), 128'(0));
        man_rel_id = 2;
        man_rel_seq++;
        repeat (10) @(posedge clk);
        #1;
        chk("exh_rel2_no_progress", 128'(hs_count), 128'(4));
        man_rel_id = 0;
        man_rel_seq++;
        b = 0;
        while (hs_count < 5 && b < 20) begin @(posedge clk); #1; b++; end
        chk("exh_rel0_progress", 128'(hs_count), 128'(5));
        auto_rel = 1'b1;
        wait_idle();

        // Reset while in SEND, then tag 0 is reused
        do_reset();
        auto_rel    = 1'b0;
        ready_force = 1'b0;
        issue_cmd(64'h5000, 32'd128);
        b = 0;
        while (!dma_rd_valid && b < 20) begin @(negedge clk); b++; end
        chk("mid_send_valid", 128'(dma_rd_valid), 128'(1));
        do_reset();
        ready_force = 1'b1;
        auto_rel    = 1'b1;
        issue_cmd(64'h6000, 32'd64);
        wait_idle();

        // Randomized phase
        ready_random = 1'b1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: addr = {$urandom, $urandom};
                1: addr = {32'($urandom), 20'($urandom), 12'h000} + 64'(MAX - $urandom_range(1, 16));
                2: addr = 64'hFFFF_FFFF_FFFF_F000 + 64'($urandom_range(0, 4095));
                default: addr = 64'($urandom_range(0, 65535));
            endcase
            len = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 1600));
            issue_cmd(addr, len);
        end
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("final_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
